// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared widths, state encoding and frame type for the result drain
package conv_pkg;

  localparam int DATA_W = 32;
  localparam int LANES  = 4;
  localparam int LANE_W = $clog2(LANES);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } drain_state_t;

  // Lane 0 sits in the lowest slice so frame[lane] selects the word directly.
  typedef logic [LANES-1:0][DATA_W-1:0] frame_t;

endpackage

// File: rtl/conv_result_drain_if.sv
// rtl/conv_result_drain_if.sv - valid/ready result word stream with lane index and frame marker
interface conv_result_drain_if;
  import conv_pkg::*;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [LANE_W-1:0] out_idx;
  logic              out_last;

  modport master (output out_valid, out_data, out_idx, out_last, input out_ready);
  modport slave  (input out_valid, out_data, out_idx, out_last, output out_ready);

endinterface

// File: rtl/conv_frame_fifo.sv
// rtl/conv_frame_fifo.sv - DEPTH-entry FIFO holding whole result frames
module conv_frame_fifo
  import conv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  frame_t                 din,
  output frame_t                 dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  frame_t             mem_q [DEPTH];
  frame_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push, do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy; a push into a full FIFO only lands alongside a pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Frame storage carries no reset; occupancy decides what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/conv_result_drain.sv
// rtl/conv_result_drain.sv - captures systolic result frames and serialises them one word per beat
module conv_result_drain
  import conv_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter bit RELU_EN = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cap,
  input  logic [DATA_W-1:0]   mem_data1,
  input  logic [DATA_W-1:0]   mem_data2,
  input  logic [DATA_W-1:0]   mem_data3,
  input  logic [DATA_W-1:0]   mem_data4,
  conv_result_drain_if.master out_if,
  output logic [7:0]          frame_cnt,
  output logic                overflow,
  output logic                busy
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  drain_state_t      state_q, state_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  logic              overflow_q, overflow_d;

  frame_t            cap_frame;
  frame_t            head;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              push, pop, beat_fire, last_lane;
  logic [DATA_W-1:0] word;

  assign cap_frame = {mem_data4, mem_data3, mem_data2, mem_data1};
  assign last_lane = (lane_q == LANE_W'(LANES - 1));

  conv_frame_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (cap_frame),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Capture/drop decision and serialiser next-state: lane walk, frame pop and completion count.
  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    frame_cnt_d = frame_cnt_q;
    overflow_d  = overflow_q;
    beat_fire   = (state_q == ST_SEND) && out_if.out_ready;
    pop         = beat_fire && last_lane;
    push        = cap && (!fifo_full || pop);
    if (cap && !push) begin
      overflow_d = 1'b1;
    end
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_SEND;
      end
      ST_SEND: begin
        if (beat_fire) begin
          if (last_lane) begin
            lane_d      = '0;
            frame_cnt_d = frame_cnt_q + 8'd1;
            // Keep streaming without a bubble if another frame remains after this pop.
            if (fifo_count == CNT_W'(1) && !push) state_d = ST_IDLE;
          end else begin
            lane_d = lane_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read path: head word for the current lane, optionally clamped; stored data stays untouched.
  always_comb begin
    word = head[lane_q];
    if (RELU_EN && word[DATA_W-1]) begin
      word = '0;
    end
    out_if.out_valid = (state_q == ST_SEND);
    out_if.out_data  = (state_q == ST_SEND) ? word : '0;
    out_if.out_idx   = lane_q;
    out_if.out_last  = (state_q == ST_SEND) && last_lane;
  end

  // Serialiser and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      lane_q      <= '0;
      frame_cnt_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      frame_cnt_q <= frame_cnt_d;
      overflow_q  <= overflow_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign overflow  = overflow_q;
  assign busy      = (state_q == ST_SEND) || !fifo_empty;

endmodule

// File: tb/tb_conv_result_drain.sv
// tb/tb_conv_result_drain.sv - directed bench for the result drain, plain and ReLU instances
module tb_conv_result_drain;
  import conv_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cap = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] md1 = '0, md2 = '0, md3 = '0, md4 = '0;
  logic [7:0]  fc0, fc1;
  logic        ov0, ov1, busy0, busy1;

  int n_total = 0;
  int n_bad = 0;

  logic [31:0] got0 [$];
  logic [31:0] got1 [$];
  logic [1:0]  gidx [$];
  logic        glast [$];

  conv_result_drain_if ifc0 ();
  conv_result_drain_if ifc1 ();
  assign ifc0.out_ready = out_ready;
  assign ifc1.out_ready = out_ready;

  conv_result_drain #(.DEPTH(4), .RELU_EN(1'b0)) u0 (
    .clk(clk), .reset(reset), .cap(cap),
    .mem_data1(md1), .mem_data2(md2), .mem_data3(md3), .mem_data4(md4),
    .out_if(ifc0), .frame_cnt(fc0), .overflow(ov0), .busy(busy0)
  );

  conv_result_drain #(.DEPTH(4), .RELU_EN(1'b1)) u1 (
    .clk(clk), .reset(reset), .cap(cap),
    .mem_data1(md1), .mem_data2(md2), .mem_data3(md3), .mem_data4(md4),
    .out_if(ifc1), .frame_cnt(fc1), .overflow(ov1), .busy(busy1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    cap = 1'b0;
    out_ready = 1'b0;
    step;
    step;
    reset = 1'b0;
    step;
  endtask

  task automatic do_cap(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input logic [31:0] d);
    cap = 1'b1;
    md1 = a; md2 = b; md3 = c; md4 = d;
    step;
    cap = 1'b0;
  endtask

  // Collects n handshakes; stall=1 drives ready as 1,0,0,1 repeating and checks held beats stay put.
  task automatic drain(input int n, input bit stall, input int max_cyc);
    int got = 0;
    int cyc = 0;
    bit held = 1'b0;
    logic [31:0] pd;
    logic [1:0]  pi;
    logic        pl;
    got0.delete(); got1.delete(); gidx.delete(); glast.delete();
    while (got < n && cyc < max_cyc) begin
      out_ready = stall ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
      if (held) begin
        check("hold_data", ifc0.out_data, pd);
        check("hold_idx", 32'(ifc0.out_idx), 32'(pi));
        check("hold_last", 32'(ifc0.out_last), 32'(pl));
      end
      if (ifc1.out_valid && out_ready) got1.push_back(ifc1.out_data);
      if (ifc0.out_valid && out_ready) begin
        got0.push_back(ifc0.out_data);
        gidx.push_back(ifc0.out_idx);
        glast.push_back(ifc0.out_last);
        got++;
        held = 1'b0;
      end else if (ifc0.out_valid) begin
        held = 1'b1;
        pd = ifc0.out_data;
        pi = ifc0.out_idx;
        pl = ifc0.out_last;
      end else begin
        held = 1'b0;
      end
      step;
      cyc++;
    end
    out_ready = 1'b0;
    check("beat_count", got, n);
  endtask

  task automatic check_beat(input int i, input logic [31:0] d, input logic [1:0] idx);
    if (i < got0.size()) begin
      check("beat_data", got0[i], d);
      check("beat_idx", 32'(gidx[i]), 32'(idx));
      check("beat_last", 32'(glast[i]), 32'(idx == 2'd3));
    end else begin
      check("beat_missing", i, got0.size());
    end
  endtask

  logic [31:0] f0 [4];

  initial begin
    int g;
    do_reset;
    check("rst_valid", 32'(ifc0.out_valid), 0);
    check("rst_data", ifc0.out_data, 0);
    check("rst_last", 32'(ifc0.out_last), 0);
    check("rst_busy", 32'(busy0), 0);
    check("rst_fcnt", 32'(fc0), 0);
    check("rst_ovf", 32'(ov0), 0);

    // Single frame, full-rate drain
    f0[0] = 32'd10; f0[1] = 32'hFFFF_FFFB; f0[2] = 32'd30; f0[3] = 32'd40;
    do_cap(f0[0], f0[1], f0[2], f0[3]);
    check("lat_valid_n", 32'(ifc0.out_valid), 0);
    check("lat_busy", 32'(busy0), 1);
    step;
    check("lat_valid_n1", 32'(ifc0.out_valid), 1);
    check("lat_idx", 32'(ifc0.out_idx), 0);
    drain(4, 1'b0, 20);
    for (int i = 0; i < 4; i++) check_beat(i, f0[i], 2'(i));
    check("single_fcnt", 32'(fc0), 1);
    check("single_busy", 32'(busy0), 0);
    check("single_valid", 32'(ifc0.out_valid), 0);

    // Same frame under backpressure
    do_cap(f0[0], f0[1], f0[2], f0[3]);
    drain(4, 1'b1, 40);
    for (int i = 0; i < 4; i++) check_beat(i, f0[i], 2'(i));
    out_ready = 1'b1;
    step; step;
    out_ready = 1'b0;
    check("bp_no_extra", 32'(ifc0.out_valid), 0);
    check("bp_fcnt", 32'(fc0), 2);

    // Overflow: five captures into a four-deep FIFO with the sink stalled
    do_reset;
    for (int k = 1; k <= 5; k++) do_cap(k*16, k*16+1, k*16+2, k*16+3);
    check("ovf_flag", 32'(ov0), 1);
    check("ovf_count", 32'(u0.u_fifo.count_q), 4);
    drain(16, 1'b0, 60);
    for (int i = 0; i < 16; i++) check_beat(i, (i/4+1)*16 + i%4, 2'(i%4));
    check("ovf_fcnt", 32'(fc0), 4);
    check("ovf_busy", 32'(busy0), 0);
    check("ovf_sticky", 32'(ov0), 1);

    // Full FIFO with a capture landing on the lane-3 handshake
    do_reset;
    for (int k = 1; k <= 4; k++) do_cap(k*16, k*16+1, k*16+2, k*16+3);
    out_ready = 1'b1;
    g = 0;
    while (!(ifc0.out_valid && ifc0.out_idx == 2'd3) && g < 20) begin
      step;
      g++;
    end
    check("pop_reach", 32'(g < 20), 1);
    do_cap(80, 81, 82, 83);
    out_ready = 1'b0;
    check("pop_ovf", 32'(ov0), 0);
    check("pop_count", 32'(u0.u_fifo.count_q), 4);
    check("pop_fcnt", 32'(fc0), 1);
    drain(16, 1'b0, 60);
    for (int i = 0; i < 16; i++) check_beat(i, (i/4+2)*16 + i%4, 2'(i%4));
    check("pop_fcnt_end", 32'(fc0), 5);

    // ReLU instance clamps negatives; plain instance stays bit-exact
    do_reset;
    do_cap(32'hFFFF_FFFF, 32'h0, 32'h7FFF_FFFF, 32'h8000_0000);
    drain(4, 1'b0, 20);
    check("relu_n", got1.size(), 4);
    if (got1.size() == 4) begin
      check("relu0", got1[0], 32'h0);
      check("relu1", got1[1], 32'h0);
      check("relu2", got1[2], 32'h7FFF_FFFF);
      check("relu3", got1[3], 32'h0);
    end
    check_beat(0, 32'hFFFF_FFFF, 2'd0);
    check_beat(3, 32'h8000_0000, 2'd3);

    // Reset in the middle of a frame
    do_reset;
    do_cap(100, 101, 102, 103);
    do_cap(200, 201, 202, 203);
    drain(6, 1'b0, 30);
    check("mid_fcnt_pre", 32'(fc0), 1);
    check("mid_idx_pre", 32'(ifc0.out_idx), 2);
    #2;
    reset = 1'b1;
    #1;
    check("mid_valid", 32'(ifc0.out_valid), 0);
    check("mid_busy", 32'(busy0), 0);
    check("mid_fcnt", 32'(fc0), 0);
    check("mid_idx", 32'(ifc0.out_idx), 0);
    step;
    reset = 1'b0;
    step;
    check("mid_empty", 32'(busy0), 0);
    do_cap(300, 301, 302, 303);
    drain(4, 1'b0, 20);
    for (int i = 0; i < 4; i++) check_beat(i, 300 + i, 2'(i));
    check("mid_fcnt_end", 32'(fc0), 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
